// File: rtl/frame_slicer_pkg.sv
`default_nettype none
// ============================================================================
// frame_slicer_pkg : shared code-rate encodings, slicer state type, defaults
// Revision: 1.0
// ============================================================================
package frame_slicer_pkg;

   localparam logic CODE_RATE_2 = 1'b0;
   localparam logic CODE_RATE_3 = 1'b1;

   typedef enum logic [0:0] {
      SLC_IDLE  = 1'b0,
      SLC_SLICE = 1'b1
   } slicer_state_t;

   localparam int FRAME_W_DEF = 276;
   localparam int SYMS_DEF    = 2;
   localparam int MAX_N_DEF   = 3;

   function automatic int slices_per_frame(input int frame_w, input int syms, input logic code_rate);
      return (code_rate == CODE_RATE_3) ? frame_w / (syms * 3) : frame_w / (syms * 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_slicer_slice_extract.sv
`default_nettype none
// ============================================================================
// slice_extract : combinational frame/k/rate -> per-cycle symbol group mapper
// Revision: 1.0
// ============================================================================
module slice_extract
   import frame_slicer_pkg::*;
#(
   parameter int  FRAME_W = FRAME_W_DEF,
   parameter int  SYMS    = SYMS_DEF,
   parameter int  MAX_N   = MAX_N_DEF,
   localparam int K_W     = $clog2(FRAME_W / (2 * SYMS))
) (
   input  logic [FRAME_W-1:0]    i_frame,
   input  logic [K_W-1:0]        i_k,
   input  logic                  i_code_rate,
   output logic [SYMS*MAX_N-1:0] o_rx
);

   localparam int c_p_w = $clog2(FRAME_W);

   logic [c_p_w-1:0]  w_base2;
   logic [c_p_w-1:0]  w_base3;
   logic [SYMS*2-1:0] w_slice2;
   logic [SYMS*3-1:0] w_slice3;
   logic              w_rate3;

   // Top bit of the slice moves down by SYMS*n per step of k.
   assign w_base2  = c_p_w'(FRAME_W - 1 - int'(i_k) * SYMS * 2);
   assign w_base3  = c_p_w'(FRAME_W - 1 - int'(i_k) * SYMS * 3);
   assign w_slice2 = i_frame[w_base2 -: SYMS*2];
   assign w_slice3 = i_frame[w_base3 -: SYMS*3];
   assign w_rate3  = (i_code_rate == CODE_RATE_3);

   for (genvar s = 0; s < SYMS; s++) begin : g_sym
      for (genvar j = 0; j < MAX_N; j++) begin : g_bit
         if (j < 2) begin : g_rate23
            assign o_rx[s*MAX_N+j] = w_rate3 ? w_slice3[SYMS*3-1-s*3-j]
                                             : w_slice2[SYMS*2-1-s*2-j];
         end else if (j == 2) begin : g_rate3
            assign o_rx[s*MAX_N+j] = w_rate3 & w_slice3[SYMS*3-1-s*3-j];
         end else begin : g_unused
            assign o_rx[s*MAX_N+j] = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/frame_slicer.sv
`default_nettype none
// ============================================================================
// frame_slicer : accepts whole frames, emits MSB-first symbol slices (rate 1/2, 1/3)
// Revision: 1.0
// ============================================================================
module frame_slicer
   import frame_slicer_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF,
   parameter int SYMS    = SYMS_DEF,
   parameter int MAX_N   = MAX_N_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en,
   input  logic                  i_code_rate,
   input  logic [FRAME_W-1:0]    i_frame,
   input  logic                  i_frame_valid,
   input  logic                  i_frame_last,
   output logic                  o_frame_ready,
   output logic [SYMS*MAX_N-1:0] o_rx,
   output logic                  o_rx_valid,
   input  logic                  i_rx_ready,
   output logic                  o_code_rate,
   output logic                  o_ood
);

   localparam int             c_k_w     = $clog2(FRAME_W / (2 * SYMS));
   localparam logic [c_k_w-1:0] c_k_last2 = c_k_w'(slices_per_frame(FRAME_W, SYMS, CODE_RATE_2) - 1);
   localparam logic [c_k_w-1:0] c_k_last3 = c_k_w'(slices_per_frame(FRAME_W, SYMS, CODE_RATE_3) - 1);

   slicer_state_t           r_state;
   slicer_state_t           w_state_nxt;
   logic [c_k_w-1:0]        r_k;
   logic [FRAME_W-1:0]      r_frame;
   logic                    r_rate;
   logic                    r_last;

   logic [SYMS*MAX_N-1:0]   w_rx;
   logic                    w_valid;
   logic                    w_last_slice;
   logic                    w_xfer;
   logic                    w_ready;
   logic                    w_accept;

   assign w_valid      = i_en & (r_state == SLC_SLICE);
   assign w_last_slice = (r_k == ((r_rate == CODE_RATE_3) ? c_k_last3 : c_k_last2));
   assign w_xfer       = w_valid & i_rx_ready;
   // Ready is also held low while reset is asserted, even though IDLE is forced.
   assign w_ready      = rst & i_en & ((r_state == SLC_IDLE) | (w_xfer & w_last_slice));
   assign w_accept     = w_ready & i_frame_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= SLC_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SLC_IDLE:  if (w_accept) w_state_nxt = SLC_SLICE;
         SLC_SLICE: if (w_xfer && w_last_slice && !w_accept) w_state_nxt = SLC_IDLE;
         default:   w_state_nxt = SLC_IDLE;
      endcase
   end

   always_comb begin
      o_frame_ready = w_ready;
      o_rx_valid    = w_valid;
      o_rx          = w_valid ? w_rx : '0;
      o_code_rate   = w_valid & r_rate;
      o_ood         = w_valid & w_last_slice & r_last;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k     <= '0;
         r_frame <= '0;
         r_rate  <= CODE_RATE_2;
         r_last  <= 1'b0;
      end else if (w_accept) begin
         r_k     <= '0;
         r_frame <= i_frame;
         r_rate  <= i_code_rate;
         r_last  <= i_frame_last;
      end else if (w_xfer) begin
         r_k     <= r_k + c_k_w'(1);
      end
   end

   slice_extract #(
      .FRAME_W (FRAME_W),
      .SYMS    (SYMS),
      .MAX_N   (MAX_N)
   ) u_slice_extract (
      .i_frame     (r_frame),
      .i_k         (r_k),
      .i_code_rate (r_rate),
      .o_rx        (w_rx)
   );

endmodule
`default_nettype wire
